hazard_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 57 +++++
 rtl/hazard_shadow.sv | 29 ++
 rtl/hazard_unit.sv | 126 ++++++++++++
 tb/tb_hazard_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcode constants, source/destination decode helpers,
// and the per-stage shadow attributes that the hazard controller tracks.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } shadow_t;

    localparam shadow_t SHADOW_BUBBLE = '0;

    typedef enum logic [1:0] {
        MODE_RESET,
        MODE_FREEZE,
        MODE_HAZARD,
        MODE_ISSUE
    } mode_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    // Same bit test the control decoder uses, so both agree on which opcodes write rd.
    function automatic logic writes_reg(input logic [6:0] op);
        return op[4] | ~op[5];
    endfunction

    function automatic logic is_load(input logic [6:0] op);
        return op[6:4] == 3'b000;
    endfunction

    // x0 never produces a value, so its write/load attributes are dropped at capture.
    function automatic shadow_t make_shadow(input logic [6:0] op, input logic [4:0] rd);
        shadow_t s;
        s.rd = rd;
        s.wr = writes_reg(op) && (rd != 5'd0);
        s.ld = is_load(op) && (rd != 5'd0);
        return s;
    endfunction

    function automatic logic rd_match(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && (rs == rd) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_shadow.sv
// Two-stage EX/MEM shadow of destination attributes, advancing in lockstep with the pipe.
// Latency: one cycle per stage. Hold freezes both stages; bubble loads an empty EX entry.
// Backpressure: hold has priority over advance; reset clears both stages to bubbles.
module hazard_shadow
    import riscv_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold,
    input  logic       inject_bubble,
    input  shadow_t    id_attr,
    output shadow_t    ex_stage,
    output logic [4:0] mem_rd,
    output logic       mem_ld
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_stage <= SHADOW_BUBBLE;
            mem_rd   <= 5'd0;
            mem_ld   <= 1'b0;
        end else if (!hold) begin
            ex_stage <= inject_bubble ? SHADOW_BUBBLE : id_attr;
            mem_rd   <= ex_stage.rd;
            mem_ld   <= ex_stage.ld;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// ID-side hazard/stall controller: bubbles on load-use and branch operand hazards, freezes on memory stalls.
// Latency: all control outputs are combinational from IF/ID fields and shadow state.
// Backpressure: memory stall freezes everything and defers any pending hazard; lost cycles are counted.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [6:0]       Op_i,
    input  logic [4:0]       RS1addr_i,
    input  logic [4:0]       RS2addr_i,
    input  logic [4:0]       RDaddr_i,
    input  logic             Branch_taken_i,
    input  logic             Mem_stall_i,
    output logic             No_Op_o,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             Flush_o,
    output logic             Stall_o,
    output logic [CNT_W-1:0] Stall_cnt_o
);

    shadow_t    ex_stage;
    logic [4:0] mem_rd;
    logic       mem_ld;

    logic       is_branch;
    logic       use_rs1;
    logic       use_rs2;
    logic       ex_hit;
    logic       mem_hit;
    logic       hazard;
    mode_t      mode;

    logic       shadow_hold;
    logic       shadow_bubble;
    shadow_t    id_attr;

    logic [CNT_W-1:0] stall_cnt;

    always_comb begin
        is_branch = (Op_i == OP_BRANCH);
        use_rs1   = uses_rs1(Op_i);
        use_rs2   = uses_rs2(Op_i);

        ex_hit  = rd_match(use_rs1, RS1addr_i, ex_stage.rd) |
                  rd_match(use_rs2, RS2addr_i, ex_stage.rd);
        mem_hit = rd_match(use_rs1, RS1addr_i, mem_rd) |
                  rd_match(use_rs2, RS2addr_i, mem_rd);

        // Branches resolve in ID, so they need EX results too; ALU ops get them forwarded.
        hazard = valid_i & ((~is_branch & ex_hit & ex_stage.ld) |
                            ( is_branch & ex_hit & ex_stage.wr) |
                            ( is_branch & mem_hit & mem_ld));

        if (rst_i) begin
            mode = MODE_RESET;
        end else if (Mem_stall_i) begin
            mode = MODE_FREEZE;
        end else if (hazard) begin
            mode = MODE_HAZARD;
        end else begin
            mode = MODE_ISSUE;
        end
    end

    always_comb begin
        No_Op_o      = 1'b1;
        PCWrite_o    = 1'b0;
        IFID_Write_o = 1'b0;
        Flush_o      = 1'b0;
        Stall_o      = 1'b0;
        case (mode)
            MODE_RESET: begin
                No_Op_o = 1'b1;
            end
            MODE_FREEZE: begin
                No_Op_o = 1'b0;
                Stall_o = 1'b1;
            end
            MODE_HAZARD: begin
                No_Op_o = 1'b1;
            end
            MODE_ISSUE: begin
                No_Op_o      = ~valid_i;
                PCWrite_o    = 1'b1;
                IFID_Write_o = 1'b1;
                Flush_o      = valid_i & is_branch & Branch_taken_i;
            end
            default: begin
                No_Op_o = 1'b1;
            end
        endcase
    end

    always_comb begin
        shadow_hold   = (mode == MODE_FREEZE);
        shadow_bubble = (mode == MODE_HAZARD) || !valid_i;
        id_attr       = make_shadow(Op_i, RDaddr_i);
    end

    hazard_shadow u_shadow (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .hold          (shadow_hold),
        .inject_bubble (shadow_bubble),
        .id_attr       (id_attr),
        .ex_stage      (ex_stage),
        .mem_rd        (mem_rd),
        .mem_ld        (mem_ld)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (((mode == MODE_FREEZE) || (mode == MODE_HAZARD)) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign Stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed vector table for the documented hazard scenarios, then random traffic against a
// distance-based reference model; a 2-bit-counter instance shares the stimulus to check saturation.
module tb_hazard_unit;

    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_JAL    = 7'b1101111;

    // {No_Op, PCWrite, IFID_Write, Flush, Stall}
    localparam logic [4:0] C_RST   = 5'b10000;
    localparam logic [4:0] C_HAZ   = 5'b10000;
    localparam logic [4:0] C_FRZ   = 5'b00001;
    localparam logic [4:0] C_ISS   = 5'b01100;
    localparam logic [4:0] C_BUB   = 5'b11100;
    localparam logic [4:0] C_FLUSH = 5'b01110;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       valid_i = 1'b0;
    logic [6:0] Op_i = 7'd0;
    logic [4:0] RS1addr_i = 5'd0;
    logic [4:0] RS2addr_i = 5'd0;
    logic [4:0] RDaddr_i = 5'd0;
    logic       Branch_taken_i = 1'b0;
    logic       Mem_stall_i = 1'b0;

    logic        No_Op_o, PCWrite_o, IFID_Write_o, Flush_o, Stall_o;
    logic [15:0] Stall_cnt_o;
    logic        s_no_op, s_pcw, s_ifidw, s_flush, s_stall;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .Op_i(Op_i),
        .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .Branch_taken_i(Branch_taken_i), .Mem_stall_i(Mem_stall_i),
        .No_Op_o(No_Op_o), .PCWrite_o(PCWrite_o), .IFID_Write_o(IFID_Write_o),
        .Flush_o(Flush_o), .Stall_o(Stall_o), .Stall_cnt_o(Stall_cnt_o)
    );

    hazard_unit #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .Op_i(Op_i),
        .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .Branch_taken_i(Branch_taken_i), .Mem_stall_i(Mem_stall_i),
        .No_Op_o(s_no_op), .PCWrite_o(s_pcw), .IFID_Write_o(s_ifidw),
        .Flush_o(s_flush), .Stall_o(s_stall), .Stall_cnt_o(s_cnt)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       tk;
        logic       ms;
        logic [4:0] ctrl;
        int         cnt;
    } vec_t;

    typedef struct {
        bit         v;
        logic [6:0] op;
        logic [4:0] rd;
    } inst_t;

    vec_t  vecs[$];
    inst_t m_ex, m_mem;
    int    m_cnt, m_sat;
    int    errors = 0;
    int    checks = 0;

    function automatic bit m_writes(input logic [6:0] op);
        return op[4] | ~op[5];
    endfunction

    function automatic bit m_load(input logic [6:0] op);
        return op[6:4] == 3'b000;
    endfunction

    // A producer at pipeline distance d (1 = EX, 2 = MEM) is usable only if d reaches the
    // distance its result needs: ALU ops feed ALU ops at 1, branches need one more stage,
    // loads one more again.
    function automatic bit m_hazard(input bit v, input logic [6:0] op, input logic [4:0] a, input logic [4:0] b);
        logic [4:0] srcs[2];
        int   nsrc;
        bit   br;
        inst_t p;
        int   need;
        if (!v) return 0;
        br = (op == T_BRANCH);
        srcs[0] = a;
        srcs[1] = b;
        case (op)
            T_R, T_STORE, T_BRANCH: nsrc = 2;
            T_I, T_LOAD:            nsrc = 1;
            default:                nsrc = 0;
        endcase
        for (int s = 0; s < nsrc; s++) begin
            for (int d = 1; d <= 2; d++) begin
                p = (d == 1) ? m_ex : m_mem;
                if (p.v && m_writes(p.op) && p.rd != 5'd0 && p.rd == srcs[s]) begin
                    need = br ? (m_load(p.op) ? 3 : 2) : (m_load(p.op) ? 2 : 1);
                    if (d < need) return 1;
                end
            end
        end
        return 0;
    endfunction

    task automatic add(input logic r, input logic v, input logic [6:0] op, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d, input logic tk, input logic ms,
                       input logic [4:0] c, input int n);
        vec_t e;
        e.rst = r; e.v = v; e.op = op; e.rs1 = a; e.rs2 = b; e.rd = d;
        e.tk = tk; e.ms = ms; e.ctrl = c; e.cnt = n;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input int idx, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    // Drives one cycle just after a falling edge, checks mid-cycle, and advances the model.
    task automatic run_cycle(input int idx, input logic r, input logic v, input logic [6:0] op,
                             input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                             input logic tk, input logic ms, input bit use_tab,
                             input logic [4:0] t_ctrl, input int t_cnt);
        bit hz;
        logic [4:0] m_ctrl;
        rst_i = r; valid_i = v; Op_i = op; RS1addr_i = a; RS2addr_i = b; RDaddr_i = d;
        Branch_taken_i = tk; Mem_stall_i = ms;
        #1;
        hz = m_hazard(v, op, a, b);
        if (r)       m_ctrl = C_RST;
        else if (ms) m_ctrl = C_FRZ;
        else if (hz) m_ctrl = C_HAZ;
        else         m_ctrl = {~v, 1'b1, 1'b1, v & (op == T_BRANCH) & tk, 1'b0};
        check("ctrl", idx, {No_Op_o, PCWrite_o, IFID_Write_o, Flush_o, Stall_o},
              use_tab ? t_ctrl : m_ctrl);
        check("stall_cnt", idx, Stall_cnt_o, use_tab ? t_cnt : m_cnt);
        check("stall_cnt_sat", idx, s_cnt, m_sat);
        if (r) begin
            m_ex = '{0, 7'd0, 5'd0};
            m_mem = '{0, 7'd0, 5'd0};
            m_cnt = 0;
            m_sat = 0;
        end else if (ms || hz) begin
            if (!ms) begin
                m_mem = m_ex;
                m_ex = '{0, 7'd0, 5'd0};
            end
            if (m_cnt < 65535) m_cnt++;
            if (m_sat < 3) m_sat++;
        end else begin
            m_mem = m_ex;
            m_ex = '{v, op, d};
        end
        @(negedge clk);
    endtask

    initial begin
        m_ex = '{0, 7'd0, 5'd0};
        m_mem = '{0, 7'd0, 5'd0};
        m_cnt = 0;
        m_sat = 0;

        //   rst v  op        rs1 rs2 rd tk ms  ctrl     cnt
        add(1, 0, T_R,      0, 0, 0, 0, 0, C_RST,   0);
        // load-use: one bubble
        add(0, 1, T_LOAD,   1, 0, 5, 0, 0, C_ISS,   0);
        add(0, 1, T_R,      5, 1, 6, 0, 0, C_HAZ,   0);
        add(0, 1, T_R,      5, 1, 6, 0, 0, C_ISS,   1);
        add(0, 0, T_R,      0, 0, 0, 0, 0, C_BUB,   1);
        // taken branch on a load: two bubbles then flush
        add(0, 1, T_LOAD,   1, 0, 5, 0, 0, C_ISS,   1);
        add(0, 1, T_BRANCH, 5, 0, 0, 1, 0, C_HAZ,   1);
        add(0, 1, T_BRANCH, 5, 0, 0, 1, 0, C_HAZ,   2);
        add(0, 1, T_BRANCH, 5, 0, 0, 1, 0, C_FLUSH, 3);
        add(0, 0, T_R,      0, 0, 0, 0, 0, C_BUB,   3);
        // branch on an EX ALU result: one bubble; on x0: none
        add(0, 1, T_R,      1, 2, 7, 0, 0, C_ISS,   3);
        add(0, 1, T_BRANCH, 7, 2, 0, 0, 0, C_HAZ,   3);
        add(0, 1, T_BRANCH, 7, 2, 0, 0, 0, C_ISS,   4);
        add(0, 1, T_R,      1, 2, 0, 0, 0, C_ISS,   4);
        add(0, 1, T_BRANCH, 0, 2, 0, 1, 0, C_FLUSH, 4);
        add(0, 0, T_R,      0, 0, 0, 0, 0, C_BUB,   4);
        // memory stall defers a load-use hazard
        add(0, 1, T_LOAD,   1, 0, 5, 0, 0, C_ISS,   4);
        add(0, 1, T_R,      5, 1, 6, 0, 1, C_FRZ,   4);
        add(0, 1, T_R,      5, 1, 6, 0, 1, C_FRZ,   5);
        add(0, 1, T_R,      5, 1, 6, 0, 1, C_FRZ,   6);
        add(0, 1, T_R,      5, 1, 6, 0, 0, C_HAZ,   7);
        add(0, 1, T_R,      5, 1, 6, 0, 0, C_ISS,   8);
        // taken flag on a non-branch is ignored
        add(0, 1, T_R,      1, 2, 9, 1, 0, C_ISS,   8);
        // reset during the second branch-on-load bubble
        add(0, 1, T_LOAD,   1, 0, 5, 0, 0, C_ISS,   8);
        add(0, 1, T_BRANCH, 5, 0, 0, 1, 0, C_HAZ,   8);
        add(1, 1, T_BRANCH, 5, 0, 0, 1, 0, C_RST,   9);
        add(0, 1, T_BRANCH, 5, 0, 0, 1, 0, C_FLUSH, 0);
        add(0, 0, T_R,      0, 0, 0, 0, 0, C_BUB,   0);

        repeat (2) @(negedge clk);

        foreach (vecs[i])
            run_cycle(i, vecs[i].rst, vecs[i].v, vecs[i].op, vecs[i].rs1, vecs[i].rs2,
                      vecs[i].rd, vecs[i].tk, vecs[i].ms, 1'b1, vecs[i].ctrl, vecs[i].cnt);

        for (int i = 0; i < 600; i++) begin
            logic [6:0] op;
            case ($urandom_range(0, 6))
                0:       op = T_R;
                1:       op = T_I;
                2:       op = T_LOAD;
                3:       op = T_STORE;
                4:       op = T_BRANCH;
                5:       op = T_LUI;
                default: op = T_JAL;
            endcase
            run_cycle(1000 + i, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 85), op,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 15),
                      1'b0, 5'd0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
